// File: rtl/omok_key_decoder.sv
// Omok key decoder: synchronizes, debounces and prioritizes six keys
// into cursor moves and one-cycle put/undo/move strobes.
// Ports: clk, rst (sync, active-low); left/right/up/down/put/undo raw keys;
//        game_over; cur_h/cur_v cursor; put_pulse/undo_pulse/move_pulse.
// Macro OMOK_KEY_AUTO_REPEAT_EN enables auto-repeat of held direction keys.
module omok_key_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BOARD_SIZE      = 10,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       put,
    input  logic       undo,
    input  logic       game_over,
    output logic [3:0] cur_h,
    output logic [3:0] cur_v,
    output logic       put_pulse,
    output logic       undo_pulse,
    output logic       move_pulse
);

    localparam int NK = 6;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] MAX_POS = 4'(BOARD_SIZE - 1);

    // key order: 0 left, 1 right, 2 up, 3 down, 4 put, 5 undo
    logic [NK-1:0] raw, sync1, sync2, deb, deb_d;
    logic [NK-1:0] press, evt, act;
    logic [CW-1:0] cnt [NK];
    logic [3:0]    rep;

    logic [3:0] nxt_h, nxt_v;
    logic       nxt_put, nxt_undo, nxt_move;

    assign raw   = {undo, put, down, up, right, left};
    assign press = deb & ~deb_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int k = 0; k < NK; k++) cnt[k] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int k = 0; k < NK; k++) begin
                if (sync2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    deb[k] <= ~deb[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

`ifdef OMOK_KEY_AUTO_REPEAT_EN
    // Each direction key times from its press: first repeat after
    // REPEAT_DELAY cycles, then every REPEAT_PERIOD until release.
    logic [15:0] rcnt [4];
    logic [3:0]  armed;

    always_comb begin
        rep = '0;
        for (int k = 0; k < 4; k++) begin
            if (deb[k] && deb_d[k]) begin
                if (armed[k])
                    rep[k] = (rcnt[k] == 16'(REPEAT_PERIOD - 1));
                else
                    rep[k] = (rcnt[k] == 16'(REPEAT_DELAY - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed <= '0;
            for (int k = 0; k < 4; k++) rcnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!deb[k] || press[k]) begin
                    rcnt[k]  <= '0;
                    armed[k] <= 1'b0;
                end else if (rep[k]) begin
                    rcnt[k]  <= '0;
                    armed[k] <= 1'b1;
                end else begin
                    rcnt[k] <= rcnt[k] + 16'd1;
                end
            end
        end
    end
`else
    assign rep = '0;
`endif

    assign evt = press | {2'b00, rep};
    // undo is always honoured; the rest are masked while game_over
    assign act = evt & {1'b1, {5{~game_over}}};

    always_comb begin
        nxt_h    = cur_h;
        nxt_v    = cur_v;
        nxt_put  = 1'b0;
        nxt_undo = 1'b0;
        nxt_move = 1'b0;
        priority case (1'b1)
            act[5]: nxt_undo = 1'b1;
            act[4]: nxt_put  = 1'b1;
            act[0]: if (cur_h != 4'd0) begin
                nxt_h    = cur_h - 4'd1;
                nxt_move = 1'b1;
            end
            act[1]: if (cur_h != MAX_POS) begin
                nxt_h    = cur_h + 4'd1;
                nxt_move = 1'b1;
            end
            act[2]: if (cur_v != 4'd0) begin
                nxt_v    = cur_v - 4'd1;
                nxt_move = 1'b1;
            end
            act[3]: if (cur_v != MAX_POS) begin
                nxt_v    = cur_v + 4'd1;
                nxt_move = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_h      <= '0;
            cur_v      <= '0;
            put_pulse  <= 1'b0;
            undo_pulse <= 1'b0;
            move_pulse <= 1'b0;
        end else begin
            cur_h      <= nxt_h;
            cur_v      <= nxt_v;
            put_pulse  <= nxt_put;
            undo_pulse <= nxt_undo;
            move_pulse <= nxt_move;
        end
    end

endmodule
